instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage feeding the decode/control path of the RV32I core. Holds the program counter, fetches 32-bit instruction words over a valid/ready instruction-memory port with a single outstanding request, and presents each instruction with its PC to the decode stage. The block supplies the opcode slice consumed by the control decoder. It takes PC redirects from branch/jump resolution, discarding stale or in-flight fetches.

## Interface

- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word-aligned fetch address (= pc)
- imem_rsp_valid  in  1  response data valid; one-cycle pulse per accepted request
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instr/instr_pc/opcode valid to decode
- instr_ready  in  1  decode consumes instruction this cycle
- instr  out  32  held instruction word
- instr_pc  out  32  address of held instruction
- opcode  out  7  instr[6:0], direct to control decoder
- redirect_valid  in  1  branch taken / jump: replace PC
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0)
- fetch_count  out  32  count of completed decode handshakes

## Operation

- States: REQ, WAIT, HOLD, DROP. Reset state: REQ.
- Registers: pc, instr, instr_pc, fetch_count, state.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, fetch_count=0, instr_valid=0. While rst=1, imem_req_valid=0.
- imem_req_valid=1 only in REQ (and rst=0); imem_addr=pc at all times.
- instr_valid=1 only in HOLD; opcode=instr[6:0] always.
- REQ:
  - redirect_valid with handshake: pc<=redirect_pc → DROP.
  - redirect_valid without handshake: pc<=redirect_pc → REQ.
  - Handshake with no redirect → WAIT.
  - Otherwise stay.
- WAIT:
  - rsp_valid with no redirect: instr<=rsp_data, instr_pc<=pc, pc<=pc+4 → HOLD.
  - rsp_valid with redirect: discard data, pc<=redirect_pc → REQ.
  - redirect without rsp_valid: pc<=redirect_pc → DROP.
- DROP:
  - rsp_valid: discard → REQ.
  - Redirect in DROP: pc<=redirect_pc; stay until rsp_valid, or go to REQ if both occur in the same cycle.
- HOLD:
  - instr_ready=1: fetch_count+=1.
  - If redirect_valid, pc<=redirect_pc; state → REQ.
  - instr_ready=0 with redirect_valid: held instruction is flushed without consuming it; fetch_count unchanged; pc<=redirect_pc → REQ.
  - Otherwise hold all outputs stable.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
  - fetch_count wraps modulo 2^32.
- redirect_valid has priority over sequential pc update in every state.
- rsp_valid outside WAIT/DROP is a protocol error and is ignored.

## Timing

- A request handshake in cycle N puts the state in WAIT at N+1. The earliest rsp_valid is at N+1, which gives instr_valid=1 at N+2.
- Zero-wait memory with instr_ready tied high gives 1 instruction per 3 cycles: REQ, WAIT, HOLD.
- Redirect in cycle N gives imem_addr=redirect_pc at N+1; a request is issued at N+1 unless a response is pending (DROP).
- Outputs are registered or decoded from state only. No combinational path runs from redirect/instr_ready to imem_req_valid.
- rst asserted in any state applies reset values at the next edge; an in-flight response arriving after reset is ignored because state=REQ.

## Test plan

- Reset with RESET_PC=0x100, then deassert. Memory has zero-wait ready, rsp one cycle later, and returns 0x00500093. Expect instr_valid at the 3rd cycle after reset, instr_pc=0x100, opcode=0x13, and a next request at 0x104.
- Hold instr_ready=0 for 5 cycles in HOLD. Expect instr/instr_pc stable, no imem_req_valid, and fetch_count unchanged. Then instr_ready=1 gives fetch_count=1.
- Assert redirect_valid (redirect_pc=0x203) in WAIT with the response delayed 3 cycles. Expect DROP, the stale word discarded, the next imem_addr=0x200, and no instr_valid for the stale word.
- In HOLD with instr=0x00000063 at pc 0x40, assert instr_ready=1 and redirect_pc=0x80 together. Expect fetch_count+1 and the next request at 0x80. Repeat with instr_ready=0: fetch_count unchanged, request at 0x80.
- With RESET_PC=0xFFFF_FFFC, fetch one instruction. Expect the next imem_addr=0x0000_0000.
- Assert rst while in WAIT, then pulse rsp_valid in the first cycle after reset. Expect the response ignored, pc=RESET_PC, instr_valid=0, and a fresh request.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the RV32I core. Owns the program counter, issues one
// instruction-memory request at a time over a valid/ready port, and holds the
// returned word (with its PC) for the decode stage until decode accepts it.
// Branch/jump redirects replace the PC at any point; a fetch already in flight
// when a redirect lands is allowed to complete and its data is thrown away.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   imem_req_valid/ready  fetch request handshake
//   imem_addr             fetch address, always equal to the PC
//   imem_rsp_valid/data   one-cycle response pulse with the instruction word
//   instr_valid/ready     decode handshake
//   instr, instr_pc       held instruction word and its address
//   opcode                instr[6:0] for the control decoder
//   redirect_valid/pc     branch/jump target (low two bits dropped)
//   fetch_count           number of completed decode handshakes (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    // REQ : request outstanding on the port, waiting for imem_req_ready
    // WAIT: request accepted, response not yet returned
    // HOLD: instruction presented to decode
    // DROP: response still owed for a fetch that a redirect made stale
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h3;

    // Outputs decode only from state (plus reset masking on the request), so
    // there is no combinational path from redirect/instr_ready to the port.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign opcode         = instr_q[6:0];
    assign fetch_count    = fetch_count_q;

    always_comb begin
        // NOTE: every next-state value starts as "hold" so that branches which
        // do not assign it cannot leave a latch behind.
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // An accepted request for the old PC still owes a response.
                    state_d = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    instr_d    = imem_rsp_data;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_HOLD;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end

            S_HOLD: begin
                if (instr_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                // A redirect without instr_ready flushes the held word unconsumed.
                if (instr_ready || redirect_valid) begin
                    state_d = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed scenarios followed by randomized traffic. A memory model answers
// fetches with an address-derived word after a configurable delay. A reference
// model keeps the architectural "next instruction decode must see" in a queue:
// sequential after each presented instruction, replaced by the target on a
// redirect, reset to the reset PC on reset. A monitor pops from it whenever
// the DUT presents a new instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    // Memory behaviour knobs: delay 0 means random 1..3 cycles.
    int   delay_mode = 1;
    logic ready_mode = 1'b1;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program image: a bijective scramble of the address, with two fixed words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        if (a == 32'h0000_0040) return 32'h0000_0063;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory model (single outstanding request) -------------
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
    end

    always begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            cnt       = (delay_mode == 0) ? int'($urandom_range(1, 3)) : delay_mode;
        end
        @(posedge clk);
        #1;
        if (pend && cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend) cnt--;
        end
        imem_req_ready = !pend && (ready_mode || ($urandom_range(0, 9) < 7));
    end

    // ---------------- reference model + scoreboard monitor ------------------
    logic [31:0] exp_q[$];
    logic [31:0] model_cnt = 32'd0;
    logic        prev_valid = 1'b0;
    logic        rst_prev = 1'b0;
    logic [31:0] held_pc = 32'd0;
    logic [31:0] held_w = 32'd0;
    int          idle = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] w;
        if (rst_prev) begin
            exp_q.delete();
            exp_q.push_back(RST_PC);
            model_cnt  = 32'd0;
            prev_valid = 1'b0;
            idle       = 0;
        end
        if (rst) begin
            check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            if (rst_prev) begin
                check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
                check("rst_fetch_count", fetch_count, 32'd0);
                check("rst_addr", imem_addr, RST_PC);
            end
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            check("fetch_count", fetch_count, model_cnt);
            if (instr_valid) begin
                if (!prev_valid) begin
                    e = exp_q.pop_front();
                    w = mem_word(e);
                    check("pres_pc", instr_pc, e);
                    check("pres_instr", instr, w);
                    check("pres_opcode", {25'd0, opcode}, {25'd0, w[6:0]});
                    held_pc = e;
                    held_w  = w;
                    exp_q.push_back(e + 32'd4);
                    idle = 0;
                end else begin
                    check("hold_pc", instr_pc, held_pc);
                    check("hold_instr", instr, held_w);
                end
                if (instr_ready) model_cnt = model_cnt + 32'd1;
            end else begin
                idle++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'h3);
            end
            prev_valid = instr_valid;
            if (idle > 200) begin
                check("fetch_timeout", idle, 32'd0);
                idle = 0;
            end
        end
    end

    // ---------------- directed helpers ---------------------------------------
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 60);
        check({name, "_wait_valid"}, {31'd0, instr_valid}, 32'd1);
    endtask

    // Apply instr_ready/redirect for one HOLD cycle, then observe the result.
    task automatic hold_action(input logic rdy, input logic redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus -----------------------------------------------
    initial begin
        int n;
        logic saw_valid;

        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // First fetch after reset: REQ, WAIT, HOLD.
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                n = i;
                break;
            end
        end
        check("first_latency", n, 32'd3);
        check("first_pc", instr_pc, 32'h0000_0100);
        check("first_opcode", {25'd0, opcode}, 32'h13);
        check("first_instr", instr, 32'h0050_0093);

        // Decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_fetch_count", fetch_count, 32'd0);
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        delay_mode  = 3;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        @(negedge clk);
        check("consume_fetch_count", fetch_count, 32'd1);
        check("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("next_req_addr", imem_addr, 32'h0000_0104);

        // Redirect while WAITing on a slow response: the response is dropped.
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        delay_mode     = 1;
        n = 0;
        saw_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (instr_valid) saw_valid = 1'b1;
            if (imem_req_valid) begin
                n = i;
                break;
            end
        end
        check("drop_no_stale_valid", {31'd0, saw_valid}, 32'd0);
        check("drop_cycles", n, 32'd3);
        check("drop_req_addr", imem_addr, 32'h0000_0200);
        wait_valid("i200");
        check("i200_pc", instr_pc, 32'h0000_0200);

        // Flush the held word with a redirect to 0x40.
        hold_action(1'b0, 1'b1, 32'h0000_0040);
        check("flush_fetch_count", fetch_count, 32'd1);
        check("flush_req_addr", imem_addr, 32'h0000_0040);
        wait_valid("i40");
        check("i40_pc", instr_pc, 32'h0000_0040);
        check("i40_instr", instr, 32'h0000_0063);

        // Consume and redirect together.
        hold_action(1'b1, 1'b1, 32'h0000_0080);
        check("consume_redir_count", fetch_count, 32'd2);
        check("consume_redir_req", {31'd0, imem_req_valid}, 32'd1);
        check("consume_redir_addr", imem_addr, 32'h0000_0080);
        wait_valid("i80");
        check("i80_pc", instr_pc, 32'h0000_0080);

        // Same again without consuming.
        hold_action(1'b0, 1'b1, 32'h0000_0040);
        wait_valid("i40b");
        check("i40b_pc", instr_pc, 32'h0000_0040);
        hold_action(1'b0, 1'b1, 32'h0000_0080);
        check("noconsume_redir_count", fetch_count, 32'd2);
        check("noconsume_redir_req", {31'd0, imem_req_valid}, 32'd1);
        check("noconsume_redir_addr", imem_addr, 32'h0000_0080);

        // PC wrap at the top of the address space.
        wait_valid("i80b");
        hold_action(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid("iwrap");
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        delay_mode = 2;
        hold_action(1'b1, 1'b0, 32'd0);
        check("wrap_fetch_count", fetch_count, 32'd3);
        check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("wrap_req_addr", imem_addr, 32'h0000_0000);

        // Reset in WAIT; the owed response lands in the first cycle after reset.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        delay_mode = 1;
        @(negedge clk);
        check("post_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("post_rst_addr", imem_addr, RST_PC);
        check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_fetch_count", fetch_count, 32'd0);
        wait_valid("post_rst");
        check("post_rst_pc", instr_pc, RST_PC);

        // Randomized traffic.
        ready_mode = 1'b0;
        delay_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst            = ($urandom_range(0, 399) == 0);
            instr_ready    = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
            else
                redirect_pc = $urandom_range(0, 1023);
        end
        @(posedge clk);
        #1;
        rst            = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
